// File: rtl/block_operand_loader.sv
// block_operand_loader
//   Fetches a 2x2 A block and a 2x2 B block (8 words) from a single-port
//   synchronous-read RAM and presents them as registered operands to the
//   2x2 base block multiplier. All eight operands update together at one
//   commit edge, and done pulses in the following cycle.
//
// Ports:
//   clk, rst          clock (rising edge), synchronous active-high reset
//   start             load request, sampled only in IDLE
//   a_base, b_base    addresses of element (1,1) of the A and B blocks
//   row_stride        words per matrix row
//   ram_addr          registered RAM read address
//   ram_r_data        RAM read data, valid the cycle after ram_addr
//   busy              high while a load is in progress (FETCH/DRAIN)
//   done              one-cycle pulse, operands valid and committed
//   a11..b22          registered operand block
module block_operand_loader #(
   parameter int data_w = 32,
   parameter int addr_w = 9
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [addr_w-1:0] a_base,
   input  logic [addr_w-1:0] b_base,
   input  logic [addr_w-1:0] row_stride,
   output logic [addr_w-1:0] ram_addr,
   input  logic [data_w-1:0] ram_r_data,
   output logic              busy,
   output logic              done,
   output logic [data_w-1:0] a11, a12, a21, a22,
   output logic [data_w-1:0] b11, b12, b21, b22
);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [2:0]        idx_q, idx_d;            // index of the address on ram_addr
   logic [addr_w-1:0] addr_q, addr_d;
   logic [addr_w-1:0] a_base_q, a_base_d;
   logic [addr_w-1:0] b_base_q, b_base_d;
   logic [addr_w-1:0] stride_q, stride_d;
   logic [data_w-1:0] shadow_q [8];
   logic [data_w-1:0] shadow_d [8];
   logic [data_w-1:0] op_q [8];
   logic [data_w-1:0] op_d [8];

   // Word k: bit2 selects the B block, bit1 the second row, bit0 the second
   // column. The sum wraps modulo 2^addr_w by truncation.
   function automatic logic [addr_w-1:0] blk_addr(input logic [2:0] k,
                                                  input logic [addr_w-1:0] a,
                                                  input logic [addr_w-1:0] b,
                                                  input logic [addr_w-1:0] s);
      logic [addr_w-1:0] base;
      base = k[2] ? b : a;
      return base + (k[1] ? s : '0) + {{(addr_w-1){1'b0}}, k[0]};
   endfunction

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      addr_d   = addr_q;
      a_base_d = a_base_q;
      b_base_d = b_base_q;
      stride_d = stride_q;
      shadow_d = shadow_q;
      op_d     = op_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d  = S_FETCH;
               a_base_d = a_base;
               b_base_d = b_base;
               stride_d = row_stride;
               idx_d    = 3'd0;
               addr_d   = a_base;      // addr_0
            end
         end
         S_FETCH: begin
            // Read data lags the address by one cycle, so the word landing
            // now belongs to the previous index.
            if (idx_q != 3'd0)
               shadow_d[idx_q - 3'd1] = ram_r_data;
            if (idx_q == 3'd7) begin
               state_d = S_DRAIN;
            end else begin
               idx_d  = idx_q + 3'd1;
               addr_d = blk_addr(idx_q + 3'd1, a_base_q, b_base_q, stride_q);
            end
         end
         S_DRAIN: begin
            // Last word bypasses the shadow so all eight commit on one edge.
            shadow_d[7] = ram_r_data;
            for (int k = 0; k < 7; k++)
               op_d[k] = shadow_q[k];
            op_d[7] = ram_r_data;
            state_d = S_DONE;
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         idx_q    <= '0;
         addr_q   <= '0;
         a_base_q <= '0;
         b_base_q <= '0;
         stride_q <= '0;
         for (int k = 0; k < 8; k++) begin
            shadow_q[k] <= '0;
            op_q[k]     <= '0;
         end
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         addr_q   <= addr_d;
         a_base_q <= a_base_d;
         b_base_q <= b_base_d;
         stride_q <= stride_d;
         for (int k = 0; k < 8; k++) begin
            shadow_q[k] <= shadow_d[k];
            op_q[k]     <= op_d[k];
         end
      end
   end

   assign ram_addr = addr_q;
   assign busy     = (state_q == S_FETCH) || (state_q == S_DRAIN);
   assign done     = (state_q == S_DONE);

   assign a11 = op_q[0];
   assign a12 = op_q[1];
   assign a21 = op_q[2];
   assign a22 = op_q[3];
   assign b11 = op_q[4];
   assign b12 = op_q[5];
   assign b21 = op_q[6];
   assign b22 = op_q[7];

endmodule

// File: tb/tb_block_operand_loader.sv
module tb_block_operand_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [8:0]  a_base, b_base, row_stride;
   logic [8:0]  ram_addr;
   logic [31:0] ram_r_data;
   logic        busy, done;
   logic [31:0] a11, a12, a21, a22, b11, b12, b21, b22;

   logic [31:0] mem [512];
   logic [31:0] ops [8];
   logic [31:0] model_ops [8];   // operands the model expects to be visible
   int          n_tests = 0;
   int          n_fail  = 0;

   always #5 clk = ~clk;

   // Synchronous-read RAM: data for the address seen at an edge appears after it.
   always @(posedge clk) ram_r_data <= mem[ram_addr];

   block_operand_loader #(.data_w(32), .addr_w(9)) dut (
      .clk(clk), .rst(rst), .start(start),
      .a_base(a_base), .b_base(b_base), .row_stride(row_stride),
      .ram_addr(ram_addr), .ram_r_data(ram_r_data),
      .busy(busy), .done(done),
      .a11(a11), .a12(a12), .a21(a21), .a22(a22),
      .b11(b11), .b12(b12), .b21(b21), .b22(b22)
   );

   always_comb begin
      ops[0] = a11; ops[1] = a12; ops[2] = a21; ops[3] = a22;
      ops[4] = b11; ops[5] = b12; ops[6] = b21; ops[7] = b22;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Address of word k of a load: row k/2, column k%2 of block A (k<4) or B.
   function automatic logic [8:0] ref_addr(input int k, input logic [8:0] a,
                                           input logic [8:0] b, input logic [8:0] s);
      int base;
      base = (k < 4) ? int'(a) : int'(b);
      return 9'((base + ((k % 4) / 2) * int'(s) + (k % 2)) % 512);
   endfunction

   task automatic check_ops(input string tag, input logic [31:0] exp [8]);
      for (int k = 0; k < 8; k++) chk($sformatf("%s_op%0d", tag, k), ops[k], exp[k]);
   endtask

   // Called in cycle 0 (start will be sampled at the edge ending it).
   // extra: also pulse start in cycles 3 and 10. rst_at: assert rst in that cycle.
   task automatic run_load(input string tag, input logic [8:0] a, input logic [8:0] b,
                           input logic [8:0] s, input bit extra, input int rst_at);
      logic [8:0]  ad [8];
      logic [31:0] nw [8];
      for (int k = 0; k < 8; k++) begin
         ad[k] = ref_addr(k, a, b, s);
         nw[k] = mem[ad[k]];
      end
      a_base = a; b_base = b; row_stride = s; start = 1'b1;
      tick();
      start = 1'b0;
      // Base/stride were latched at acceptance; scramble them.
      a_base = 9'($urandom); b_base = 9'($urandom); row_stride = 9'($urandom);
      for (int c = 1; c <= 10; c++) begin
         if (c <= 8) chk($sformatf("%s_addr_c%0d", tag, c), ram_addr, ad[c-1]);
         chk($sformatf("%s_busy_c%0d", tag, c), busy, c <= 9);
         chk($sformatf("%s_done_c%0d", tag, c), done, c == 10);
         check_ops($sformatf("%s_c%0d", tag, c), (c == 10) ? nw : model_ops);
         if (c == rst_at) begin
            rst = 1'b1;
            tick();
            rst = 1'b0;
            chk({tag, "_rst_busy"}, busy, 1'b0);
            chk({tag, "_rst_done"}, done, 1'b0);
            chk({tag, "_rst_addr"}, ram_addr, 9'd0);
            for (int k = 0; k < 8; k++) model_ops[k] = '0;
            check_ops({tag, "_rst"}, model_ops);
            for (int i = 0; i < 12; i++) begin
               tick();
               chk({tag, "_postrst_done"}, done, 1'b0);
               chk({tag, "_postrst_busy"}, busy, 1'b0);
            end
            return;
         end
         start = extra && (c == 3 || c == 10);
         tick();
      end
      start = 1'b0;
      model_ops = nw;
      // Back in IDLE: nothing pending, address holds addr_7, operands hold.
      for (int i = 0; i < 3; i++) begin
         chk({tag, "_idle_busy"}, busy, 1'b0);
         chk({tag, "_idle_done"}, done, 1'b0);
         chk({tag, "_idle_addr"}, ram_addr, ad[7]);
         check_ops({tag, "_idle"}, model_ops);
         tick();
      end
   endtask

   initial begin
      logic [8:0]  ha, hb, hs;
      logic [31:0] hw [8];
      rst = 1'b1; start = 1'b1; a_base = 9'd5; b_base = 9'd7; row_stride = 9'd3;
      for (int i = 0; i < 512; i++) mem[i] = 32'(i + 100);
      for (int k = 0; k < 8; k++) model_ops[k] = '0;

      // 1: reset with start held high must not start a load.
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("rst_busy", busy, 1'b0);
         chk("rst_done", done, 1'b0);
         chk("rst_addr", ram_addr, 9'd0);
         check_ops("rst", model_ops);
      end
      @(negedge clk);
      rst = 1'b0; start = 1'b0;
      tick();

      // 2/3: basic load, then atomic switch on second load.
      run_load("basic", 9'd0, 9'd64, 9'd8, 1'b0, 0);
      chk("basic_a11", a11, 32'd100);
      chk("basic_b22", b22, 32'd173);
      run_load("atomic", 9'd2, 9'd64, 9'd8, 1'b0, 0);
      chk("atomic_a22", a22, 32'd111);

      // 4: wrap-around and zero stride.
      run_load("wrap", 9'd511, 9'd510, 9'd1, 1'b0, 0);
      chk("wrap_a21", a21, 32'd100);
      run_load("stride0", 9'd40, 9'd300, 9'd0, 1'b0, 0);
      chk("stride0_a21", a21, a11);

      // 5: start ignored while busy and in DONE.
      run_load("ignore", 9'd17, 9'd200, 9'd32, 1'b1, 0);

      // 6: reset mid-load, then a fresh load.
      run_load("midrst", 9'd100, 9'd150, 9'd16, 1'b0, 5);
      run_load("fresh", 9'd3, 9'd9, 9'd20, 1'b0, 0);

      // Randomized loads over random RAM contents.
      for (int i = 0; i < 512; i++) mem[i] = $urandom;
      for (int n = 0; n < 12; n++)
         run_load($sformatf("rnd%0d", n), 9'($urandom), 9'($urandom),
                  9'($urandom_range(0, 40)), n[0], 0);

      // Start held high: back-to-back loads, done in cycles 10 and 21.
      ha = 9'd480; hb = 9'd12; hs = 9'd30;
      for (int k = 0; k < 8; k++) hw[k] = mem[ref_addr(k, ha, hb, hs)];
      a_base = ha; b_base = hb; row_stride = hs; start = 1'b1;
      for (int c = 1; c <= 21; c++) begin
         tick();
         chk($sformatf("hold_done_c%0d", c), done, c == 10 || c == 21);
      end
      start = 1'b0;
      check_ops("hold", hw);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/block_operand_loader.md
Name: block_operand_loader

Overview:
- Fetches one 2x2 A block and one 2x2 B block (8 words) from the single-port synchronous-read RAM.
- Presents the 8 words as registered operands to the 2x2 base block multiplier, then pulses done.
- Sits directly upstream of the base multiplier. The matrix control unit supplies block base addresses and row stride, and starts the multiplier once done is seen.

Parameters:
- data_w, 32, operand/RAM word width in bits
- addr_w, 9, RAM address width in bits

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  load request; sampled only in IDLE
- a_base  in  addr_w  address of A block element (1,1)
- b_base  in  addr_w  address of B block element (1,1)
- row_stride  in  addr_w  words per matrix row
- ram_addr  out  addr_w  registered RAM read address
- ram_r_data  in  data_w  RAM read data, valid the cycle after ram_addr is presented
- busy  out  1  high while a load is in progress
- done  out  1  one-cycle pulse; operands valid and committed
- a11,a12,a21,a22,b11,b12,b21,b22  out  data_w each  registered operand block

Behaviour:
- Reset:
  - Synchronous on rst=1 at a clk edge; takes priority over everything.
  - Clears state to IDLE, the fetch index, the shadow registers, ram_addr, busy, done and all eight operand outputs to 0.
  - rst mid-load aborts it: no done pulse, outputs become 0.
- Address generation (modulo 2^addr_w, wrap silently), fetch order k=0..7:
  - k=0..3: a_base, a_base+1, a_base+S, a_base+S+1
  - k=4..7: b_base, b_base+1, b_base+S, b_base+S+1
  - S = row_stride. a_base, b_base and row_stride are latched on start acceptance; later changes have no effect on the current load.
- FSM: IDLE -> FETCH -> DRAIN -> DONE -> IDLE. Cycle numbering: start is sampled at the edge ending cycle 0.
  - IDLE: busy=0, done=0. start=1 -> FETCH; ram_addr <= addr_0.
  - FETCH, cycles 1..8: ram_addr = addr_(c-1) in cycle c. From cycle 2, ram_r_data holds word c-2 and is captured into shadow register c-2 at the end of the cycle. After the cycle presenting addr_7 -> DRAIN. busy=1.
  - DRAIN, cycle 9: capture word 7. At the end of the cycle all 8 shadow words are copied to the outputs simultaneously. busy=1.
  - DONE, cycle 10: done=1, busy=0, outputs hold the new block -> IDLE.
- Latency: done is high exactly 10 cycles after the start-sampling edge. Minimum start-to-start spacing is 11 cycles.
- Outputs change only at the commit edge. They hold their value in IDLE and during the next load until its commit. Partial data is never visible.
- ram_addr holds its last value (addr_7) outside FETCH.
- Boundary conditions:
  - start while busy or in DONE: ignored, no queueing.
  - start held high continuously: a new load begins in the cycle after each DONE.
  - row_stride=0: a21=a11, a22=a12 (same addresses refetched); legal.
  - a_base+S+1 beyond 2^addr_w-1 wraps to low addresses.
- The block never writes the RAM and has no write-enable port.

Test Plan:
1. Reset then idle: rst=1 for 2 cycles with start=1 -> busy=0, done=0, ram_addr=0, all operands 0; no load starts while rst=1.
2. Basic load: RAM[i]=i+100, a_base=0, b_base=64, row_stride=8, start pulse -> ram_addr sequence 0,1,8,9,64,65,72,73 in cycles 1..8. done high only in cycle 10; a11..a22=100,101,108,109 and b11..b22=164,165,172,173.
3. Atomic update: run scenario 2, then a second load with a_base=2 -> operands stay at the old values through cycle 9 of the second load and switch to 102,103,110,111 together with its done.
4. Wrap-around: a_base=511, row_stride=1, addr_w=9 -> A addresses 511,0,0,1.
5. Start ignored while busy: start pulses in cycles 3 and 10 of a load -> exactly one done; busy drops after cycle 9.
6. Reset mid-load: rst=1 in cycle 5 -> next cycle IDLE, operands 0, no done pulse; a fresh start then completes normally in 10 cycles.
